// File: rtl/coh_noc_vc_link_rx_if.sv
// Bundle of the receive-link signals: upstream flit/credit side plus the
// arbitrated valid/ready output. The receiver takes the slave modport.
interface coh_noc_vc_link_rx_if #(
    parameter int FLIT_W   = 731,
    parameter int NUM_VC   = 4,
    parameter int VC_DEPTH = 16,
    parameter int CNT_W    = $clog2(VC_DEPTH + 1),
    parameter int VC_W     = $clog2(NUM_VC)
);
    logic                    in_valid;
    logic [VC_W-1:0]         in_vc;
    logic [FLIT_W-1:0]       in_flit;
    logic                    out_valid;
    logic [VC_W-1:0]         out_vc;
    logic [FLIT_W-1:0]       out_flit;
    logic                    out_ready;
    logic                    credit_valid;
    logic [VC_W-1:0]         credit_vc;
    logic [NUM_VC*CNT_W-1:0] occupancy;
    logic                    ovf_err;

    modport master (
        output in_valid, in_vc, in_flit, out_ready,
        input  out_valid, out_vc, out_flit, credit_valid, credit_vc, occupancy, ovf_err
    );

    modport slave (
        input  in_valid, in_vc, in_flit, out_ready,
        output out_valid, out_vc, out_flit, credit_valid, credit_vc, occupancy, ovf_err
    );
endinterface

// File: rtl/coh_noc_vc_link_rx.sv
// Credit-based link receiver: per-VC FIFOs, round-robin output arbitration
// with a grant lock while the output is stalled, and one credit per dequeue.
module coh_noc_vc_link_rx #(
    parameter int FLIT_W   = 731,
    parameter int NUM_VC   = 4,
    parameter int VC_DEPTH = 16,
    parameter int CNT_W    = $clog2(VC_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    coh_noc_vc_link_rx_if.slave   link
);
    localparam int VC_W  = $clog2(NUM_VC);
    localparam int PTR_W = $clog2(VC_DEPTH);

    typedef enum logic {ST_ARB, ST_HOLD} state_e;

    state_e                       state_reg, state_next;
    logic [NUM_VC-1:0][CNT_W-1:0] count;
    logic [NUM_VC-1:0][FLIT_W-1:0] head;
    logic [NUM_VC-1:0]            deq;
    logic [NUM_VC-1:0]            ovf_hit;
    logic [VC_W-1:0]              rr_ptr_reg;
    logic [VC_W-1:0]              hold_vc_reg;
    logic [VC_W-1:0]              sel_rr;
    logic [VC_W-1:0]              sel;
    logic                         found;
    logic                         handshake;
    logic                         ovf_err_reg;
    logic                         credit_valid_reg;
    logic [VC_W-1:0]              credit_vc_reg;

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        logic [FLIT_W-1:0] mem [VC_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_reg;
        logic [PTR_W-1:0]  rd_ptr_reg;
        logic [CNT_W-1:0]  count_reg;
        logic              hit;
        logic              full;
        logic              enq;

        // A full VC still accepts when it is being drained in the same cycle.
        assign hit          = link.in_valid && (link.in_vc == VC_W'(gi));
        assign full         = (count_reg == CNT_W'(VC_DEPTH));
        assign enq          = hit && (!full || deq[gi]);
        assign ovf_hit[gi]  = hit && full && !deq[gi];
        assign count[gi]    = count_reg;
        assign head[gi]     = mem[rd_ptr_reg];

        always_ff @(posedge clk) begin
            if (enq) begin
                mem[wr_ptr_reg] <= link.in_flit;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (deq[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                if (enq && !deq[gi]) begin
                    count_reg <= count_reg + CNT_W'(1);
                end else if (!enq && deq[gi]) begin
                    count_reg <= count_reg - CNT_W'(1);
                end
            end
        end
    end

    // First non-empty VC starting at rr_ptr; found doubles as out_valid.
    always_comb begin
        sel_rr = rr_ptr_reg;
        found  = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!found && (count[rr_ptr_reg + VC_W'(i)] != '0)) begin
                sel_rr = rr_ptr_reg + VC_W'(i);
                found  = 1'b1;
            end
        end
    end

    assign sel       = (state_reg == ST_HOLD) ? hold_vc_reg : sel_rr;
    assign handshake = found && link.out_ready;

    always_comb begin
        deq = '0;
        if (handshake) begin
            deq[sel] = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:  if (found && !link.out_ready) state_next = ST_HOLD;
            ST_HOLD: if (link.out_ready)           state_next = ST_ARB;
            default: state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_ARB;
            rr_ptr_reg       <= '0;
            hold_vc_reg      <= '0;
            credit_valid_reg <= 1'b0;
            credit_vc_reg    <= '0;
            ovf_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_valid_reg <= handshake;
            if (state_reg == ST_ARB) begin
                hold_vc_reg <= sel_rr;
            end
            if (handshake) begin
                rr_ptr_reg    <= sel + VC_W'(1);
                credit_vc_reg <= sel;
            end
            if (|ovf_hit) begin
                ovf_err_reg <= 1'b1;
            end
        end
    end

    assign link.out_valid    = found;
    assign link.out_vc       = sel;
    assign link.out_flit     = head[sel];
    assign link.credit_valid = credit_valid_reg;
    assign link.credit_vc    = credit_vc_reg;
    assign link.occupancy    = count;
    assign link.ovf_err      = ovf_err_reg;
endmodule

// File: tb/tb_coh_noc_vc_link_rx.sv
// Bench for coh_noc_vc_link_rx: directed vector table, corner-case sequences
// and randomized traffic checked against a queue-based reference model.
module tb_coh_noc_vc_link_rx;
    localparam int FW = 731;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coh_noc_vc_link_rx_if lnk();

    coh_noc_vc_link_rx dut (
        .clk  (clk),
        .rst  (rst),
        .link (lnk.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per VC plus the arbitration bookkeeping.
    logic [FW-1:0] mq [4][$];
    int            m_rr      = 0;
    bit            m_lock    = 1'b0;
    int            m_lock_vc = 0;
    bit            m_cv      = 1'b0;
    int            m_cvc     = 0;
    bit            m_ovf     = 1'b0;

    logic [1:0]    hs_log   [$];
    logic [1:0]    cred_log [$];
    logic [FW-1:0] fl_log   [$];

    typedef struct {
        bit         r;
        bit         iv;
        logic [1:0] vc;
        int         fid;
        bit         rdy;
        bit         e_valid;
        logic [1:0] e_vc;
        int         e_fid;
        bit         e_cv;
        logic [1:0] e_cvc;
        logic [19:0] e_occ;
        bit         e_ovf;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [FW-1:0] mk(input int unsigned id);
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < 23; i++) begin
            v = {v[FW-33:0], (id + 32'(i)) * 32'h9E37_79B1};
        end
        return v;
    endfunction

    function automatic bit m_any();
        for (int v = 0; v < 4; v++) if (mq[v].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_sel();
        if (m_lock) return m_lock_vc;
        for (int i = 0; i < 4; i++) begin
            if (mq[(m_rr + i) % 4].size() != 0) return (m_rr + i) % 4;
        end
        return 0;
    endfunction

    function automatic logic [19:0] m_occ();
        logic [19:0] o;
        o = '0;
        for (int v = 0; v < 4; v++) o[v*5 +: 5] = 5'(mq[v].size());
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flit(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge, advance the model, compare after the edge.
    task automatic apply(input bit r, input bit iv, input int vc, input logic [FW-1:0] f, input bit rdy);
        bit mv;
        int sv;
        bit hs;
        bit full;
        bit deq_same;
        rst           = r;
        lnk.in_valid  = iv;
        lnk.in_vc     = 2'(vc);
        lnk.in_flit   = f;
        lnk.out_ready = rdy;
        if (!r && rdy && lnk.out_valid === 1'b1) begin
            hs_log.push_back(lnk.out_vc);
            fl_log.push_back(lnk.out_flit);
            $display("xfer t=%0t vc=%0d flit_lo=%08h", $time, lnk.out_vc, lnk.out_flit[31:0]);
        end
        if (r) begin
            for (int v = 0; v < 4; v++) mq[v].delete();
            m_rr = 0; m_lock = 1'b0; m_lock_vc = 0; m_cv = 1'b0; m_cvc = 0; m_ovf = 1'b0;
        end else begin
            mv       = m_any();
            sv       = m_sel();
            hs       = mv && rdy;
            full     = (mq[vc].size() == 16);
            deq_same = hs && (sv == vc);
            if (hs) void'(mq[sv].pop_front());
            if (iv) begin
                if (full && !deq_same) m_ovf = 1'b1;
                else mq[vc].push_back(f);
            end
            m_cv = hs;
            if (hs) begin
                m_cvc = sv;
                m_rr  = (sv + 1) % 4;
            end
            m_lock = mv && !rdy;
            if (m_lock) m_lock_vc = sv;
        end
        @(posedge clk);
        #1;
        mv = m_any();
        chk("out_valid", 64'(lnk.out_valid), 64'(mv));
        if (mv) begin
            sv = m_sel();
            chk("out_vc", 64'(lnk.out_vc), 64'(sv));
            chk_flit("out_flit", lnk.out_flit, mq[sv][0]);
        end
        chk("credit_valid", 64'(lnk.credit_valid), 64'(m_cv));
        chk("credit_vc", 64'(lnk.credit_vc), 64'(m_cvc));
        chk("occupancy", 64'(lnk.occupancy), 64'(m_occ()));
        chk("ovf_err", 64'(lnk.ovf_err), 64'(m_ovf));
        if (lnk.credit_valid === 1'b1) cred_log.push_back(lnk.credit_vc);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 0, '0, rdy);
    endtask

    initial begin
        lnk.in_valid  = 1'b0;
        lnk.in_vc     = 2'd0;
        lnk.in_flit   = '0;
        lnk.out_ready = 1'b0;

        // r iv vc fid rdy | valid vc fid cv cvc occ ovf  (outputs after the edge)
        tbl[0] = '{1'b1, 1'b1, 2'd2, 1,  1'b0, 1'b0, 2'd0, 0,  1'b0, 2'd0, 20'h00000, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 2'd2, 1,  1'b1, 1'b0, 2'd0, 0,  1'b0, 2'd0, 20'h00000, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 2'd2, 10, 1'b1, 1'b1, 2'd2, 10, 1'b0, 2'd0, 20'h00400, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 2'd0, 0,  1'b1, 1'b0, 2'd0, 0,  1'b1, 2'd2, 20'h00000, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 0,  1'b1, 1'b0, 2'd0, 0,  1'b0, 2'd2, 20'h00000, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 2'd0, 11, 1'b0, 1'b1, 2'd0, 11, 1'b0, 2'd2, 20'h00001, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 2'd3, 12, 1'b0, 1'b1, 2'd0, 11, 1'b0, 2'd2, 20'h08001, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 0,  1'b1, 1'b1, 2'd3, 12, 1'b1, 2'd0, 20'h08000, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 0,  1'b1, 1'b0, 2'd0, 0,  1'b1, 2'd3, 20'h00000, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].r, tbl[i].iv, int'(tbl[i].vc), mk(tbl[i].fid), tbl[i].rdy);
            chk("tbl_valid", 64'(lnk.out_valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk("tbl_vc", 64'(lnk.out_vc), 64'(tbl[i].e_vc));
                chk_flit("tbl_flit", lnk.out_flit, mk(tbl[i].e_fid));
            end
            chk("tbl_credit_valid", 64'(lnk.credit_valid), 64'(tbl[i].e_cv));
            chk("tbl_credit_vc", 64'(lnk.credit_vc), 64'(tbl[i].e_cvc));
            chk("tbl_occupancy", 64'(lnk.occupancy), 64'(tbl[i].e_occ));
            chk("tbl_ovf", 64'(lnk.ovf_err), 64'(tbl[i].e_ovf));
        end

        // Fairness: 3 flits per VC, then a free-running drain.
        apply(1'b1, 1'b0, 0, '0, 1'b0);
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++) apply(1'b0, 1'b1, v, mk(1000 + k*4 + v), 1'b0);
        hs_log.delete();
        cred_log.delete();
        idle(13, 1'b1);
        chk("fair_count", 64'(hs_log.size()), 64'd12);
        chk("fair_credit_count", 64'(cred_log.size()), 64'd12);
        for (int i = 0; i < hs_log.size() && i < 12; i++) chk("fair_vc", 64'(hs_log[i]), 64'(i % 4));
        for (int i = 0; i < cred_log.size() && i < 12; i++) chk("fair_credit_vc", 64'(cred_log[i]), 64'(i % 4));

        // Hold: RSP offered and stalled while REQ arrives.
        apply(1'b1, 1'b0, 0, '0, 1'b0);
        apply(1'b0, 1'b1, 1, mk(300), 1'b0);
        apply(1'b0, 1'b1, 0, mk(301), 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1, 1'b0);
            chk("hold_vc", 64'(lnk.out_vc), 64'd1);
            chk_flit("hold_flit", lnk.out_flit, mk(300));
        end
        hs_log.delete();
        idle(3, 1'b1);
        chk("hold_order_count", 64'(hs_log.size()), 64'd2);
        if (hs_log.size() == 2) begin
            chk("hold_order_first", 64'(hs_log[0]), 64'd1);
            chk("hold_order_second", 64'(hs_log[1]), 64'd0);
        end

        // Wrap/full on SNP: fill, overflow, drain, refill across the wrap.
        apply(1'b1, 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 3, mk(100 + i), 1'b0);
        chk("full_occ", 64'(lnk.occupancy[19:15]), 64'd16);
        chk("full_no_ovf", 64'(lnk.ovf_err), 64'd0);
        apply(1'b0, 1'b1, 3, mk(999), 1'b0);
        chk("ovf_set", 64'(lnk.ovf_err), 64'd1);
        chk("ovf_occ", 64'(lnk.occupancy[19:15]), 64'd16);
        idle(17, 1'b1);
        chk("drain_occ", 64'(lnk.occupancy[19:15]), 64'd0);
        for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 3, mk(200 + i), 1'b0);
        fl_log.delete();
        idle(17, 1'b1);
        chk("wrap_count", 64'(fl_log.size()), 64'd16);
        for (int i = 0; i < fl_log.size() && i < 16; i++) chk_flit("wrap_flit", fl_log[i], mk(200 + i));
        chk("ovf_sticky", 64'(lnk.ovf_err), 64'd1);

        // Full with simultaneous dequeue: enqueue accepted, no overflow.
        apply(1'b1, 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 3, mk(400 + i), 1'b0);
        apply(1'b0, 1'b1, 3, mk(416), 1'b1);
        chk("fulldeq_ovf", 64'(lnk.ovf_err), 64'd0);
        chk("fulldeq_occ", 64'(lnk.occupancy[19:15]), 64'd16);
        idle(18, 1'b1);

        // Randomized traffic with alternating back-pressure levels.
        for (int seg = 0; seg < 12; seg++) begin
            int p_rdy;
            p_rdy = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 300; c++) begin
                bit r, iv, rdy;
                r   = ($urandom_range(0, 499) == 0);
                iv  = ($urandom_range(0, 99) < 70);
                rdy = ($urandom_range(0, 99) < p_rdy);
                apply(r, iv, int'($urandom_range(0, 3)), mk($urandom), rdy);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
